// File: rtl/insn_encoder_pkg.sv
// Shared ISA definitions for the instruction encoder and decoder: opcodes, memory modes,
// encoder error codes and instruction-word field positions.
package insn_encoder_pkg;

  typedef enum logic [5:0] {
    OpNop            = 6'd0,
    OpCompute        = 6'd1,
    OpJmp            = 6'd2,
    OpAddi           = 6'd3,
    OpSubi           = 6'd4,
    OpHlt            = 6'd5,
    OpBlt            = 6'd6,
    OpBeq            = 6'd7,
    OpBneq           = 6'd8,
    OpDebugDumpstate = 6'd9,
    OpLwSw           = 6'd10
  } asm_op_e;

  typedef enum logic [1:0] {
    ModeW = 2'd0,
    ModeH = 2'd1,
    ModeB = 2'd2
  } mem_mode_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrBadOp    = 2'd1,
    ErrBadFunct = 2'd2,
    ErrOverflow = 2'd3
  } enc_err_e;

  localparam int unsigned OpcodeLsb = 0;
  localparam int unsigned OpcodeW   = 6;
  localparam int unsigned RegW      = 5;
  localparam int unsigned RdLsb     = 6;
  localparam int unsigned Rs1Lsb    = 11;
  localparam int unsigned Rs2Lsb    = 16;
  localparam int unsigned ImmLsb    = 16;
  localparam int unsigned ImmW      = 16;
  localparam int unsigned FunctLsb  = 21;
  localparam int unsigned FunctW    = 11;

endpackage

// File: rtl/insn_encoder_pack.sv
// Combinational packer: turns one symbolic instruction into its 32-bit ISA word and flags
// opcode/function errors.
module insn_pack
  import insn_encoder_pkg::*;
(
  input  asm_op_e       i_op,
  input  logic [4:0]    i_rd,
  input  logic [4:0]    i_rs1,
  input  logic [4:0]    i_rs2,
  input  logic [15:0]   i_imm,
  input  logic [10:0]   i_funct,
  input  mem_mode_e     i_ls_mode,
  input  logic          i_is_store,
  output logic [31:0]   o_word,
  output enc_err_e      o_err
);

  always_comb begin
    o_word = '0;
    o_err  = ErrNone;
    o_word[OpcodeLsb +: OpcodeW] = i_op;
    case (i_op)
      OpCompute: begin
        o_word[RdLsb +: RegW]     = i_rd;
        o_word[Rs1Lsb +: RegW]    = i_rs1;
        o_word[Rs2Lsb +: RegW]    = i_rs2;
        o_word[FunctLsb +: FunctW] = i_funct;
        if (i_funct > 11'd1) o_err = ErrBadFunct;
      end
      OpAddi, OpSubi: begin
        o_word[RdLsb +: RegW]   = i_rd;
        o_word[Rs1Lsb +: RegW]  = i_rs1;
        o_word[ImmLsb +: ImmW]  = i_imm;
      end
      // Targets are split across the rd and funct slots so rs1/rs2 stay free for compares.
      OpJmp: begin
        o_word[FunctLsb +: FunctW] = i_imm[15:RegW];
        o_word[RdLsb +: RegW]      = i_imm[RegW-1:0];
      end
      OpBlt, OpBeq, OpBneq: begin
        o_word[FunctLsb +: FunctW] = i_imm[15:RegW];
        o_word[RdLsb +: RegW]      = i_imm[RegW-1:0];
        o_word[Rs1Lsb +: RegW]     = i_rs1;
        o_word[Rs2Lsb +: RegW]     = i_rs2;
      end
      OpLwSw: begin
        o_word[RdLsb +: RegW]  = i_rd;
        o_word[Rs1Lsb +: RegW] = i_rs1;
        o_word[ImmLsb +: ImmW] = {i_is_store, 13'b0, i_ls_mode};
      end
      OpNop, OpHlt, OpDebugDumpstate: ;
      default: begin
        o_word = '0;
        o_err  = ErrBadOp;
      end
    endcase
  end

endmodule

// File: rtl/insn_encoder.sv
// Streaming instruction encoder: accepts symbolic instructions, packs them and writes them to
// consecutive instruction-memory addresses until HLT or the first illegal input.
module insn_encoder
  import insn_encoder_pkg::*;
#(
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_restart,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  asm_op_e           i_in_op,
  input  logic [4:0]        i_in_rd,
  input  logic [4:0]        i_in_rs1,
  input  logic [4:0]        i_in_rs2,
  input  logic [15:0]       i_in_imm,
  input  logic [10:0]       i_in_funct,
  input  mem_mode_e         i_in_ls_mode,
  input  logic              i_in_is_store,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic [ADDR_W-2:0] o_count,
  output logic              o_done,
  output logic              o_err,
  output enc_err_e          o_err_code
);

  typedef enum logic [1:0] {StRun, StHalting, StDone, StErr} state_e;

  // One extra address bit so the overflow compare sees past the top of the space.
  localparam logic [ADDR_W:0] BaseAddr = (ADDR_W+1)'(BASE_ADDR);
  localparam int unsigned     AddrMax  = (1 << ADDR_W) - 4;

  state_e            r_state, w_state_next;
  logic [ADDR_W:0]   r_addr;
  logic [ADDR_W-2:0] r_count;
  logic              r_wr_valid;
  logic [31:0]       r_wr_data;
  enc_err_e          r_err_code;

  logic [31:0]       w_word;
  enc_err_e          w_pack_err, w_err;
  logic              w_accept, w_wr_done;
  logic [ADDR_W:0]   w_target;

  insn_pack u_pack (
    .i_op       (i_in_op),
    .i_rd       (i_in_rd),
    .i_rs1      (i_in_rs1),
    .i_rs2      (i_in_rs2),
    .i_imm      (i_in_imm),
    .i_funct    (i_in_funct),
    .i_ls_mode  (i_in_ls_mode),
    .i_is_store (i_in_is_store),
    .o_word     (w_word),
    .o_err      (w_pack_err)
  );

  assign w_wr_done = r_wr_valid && i_wr_ready;
  // Address this instruction will land on once the pending write (if any) retires.
  assign w_target  = r_wr_valid ? r_addr + (ADDR_W+1)'(4) : r_addr;
  assign w_err     = (w_pack_err != ErrNone)   ? w_pack_err  :
                     (32'(w_target) > AddrMax) ? ErrOverflow : ErrNone;

  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    if (r_state == StRun) begin
      o_in_ready = i_rst_n && !i_restart && (!r_wr_valid || i_wr_ready);
    end
    w_accept = i_in_valid && o_in_ready;
    case (r_state)
      StRun: begin
        if (w_accept) begin
          if (w_err != ErrNone)    w_state_next = StErr;
          else if (i_in_op == OpHlt) w_state_next = StHalting;
        end
      end
      StHalting: if (w_wr_done) w_state_next = StDone;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_restart) begin
      r_state    <= StRun;
      r_addr     <= BaseAddr;
      r_count    <= '0;
      r_wr_valid <= 1'b0;
      r_wr_data  <= '0;
      r_err_code <= ErrNone;
    end else begin
      r_state <= w_state_next;
      if (w_wr_done) begin
        r_addr  <= r_addr + (ADDR_W+1)'(4);
        r_count <= r_count + (ADDR_W-1)'(1);
      end
      if (w_accept && w_err == ErrNone) begin
        r_wr_valid <= 1'b1;
        r_wr_data  <= w_word;
      end else if (w_wr_done) begin
        r_wr_valid <= 1'b0;
      end
      if (w_accept && w_err != ErrNone) r_err_code <= w_err;
    end
  end

  assign o_wr_valid = r_wr_valid;
  assign o_wr_addr  = r_addr[ADDR_W-1:0];
  assign o_wr_data  = r_wr_data;
  assign o_count    = r_count;
  assign o_done     = (r_state == StDone);
  assign o_err      = (r_state == StErr);
  assign o_err_code = r_err_code;

endmodule

// File: tb/tb_insn_encoder.sv
// Randomized and directed bench for insn_encoder, scored against an arithmetic encoding model
// and a queue of expected memory writes.
module tb_insn_encoder;
  import insn_encoder_pkg::*;

  localparam int Base = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, restart, in_valid, wr_ready, in_is_store;
  asm_op_e in_op;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [15:0] in_imm;
  logic [10:0] in_funct;
  mem_mode_e in_ls_mode;

  logic b_in_ready, b_wr_valid, b_done, b_err;
  logic [11:0] b_wr_addr;
  logic [31:0] b_wr_data;
  logic [10:0] b_count;
  enc_err_e b_err_code;
  logic s_in_ready, s_wr_valid, s_done, s_err;
  logic [3:0] s_wr_addr;
  logic [31:0] s_wr_data;
  logic [2:0] s_count;
  enc_err_e s_err_code;

  insn_encoder #(.BASE_ADDR(Base), .ADDR_W(12)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart), .i_in_valid(in_valid),
    .o_in_ready(b_in_ready), .i_in_op(in_op), .i_in_rd(in_rd), .i_in_rs1(in_rs1),
    .i_in_rs2(in_rs2), .i_in_imm(in_imm), .i_in_funct(in_funct), .i_in_ls_mode(in_ls_mode),
    .i_in_is_store(in_is_store), .o_wr_valid(b_wr_valid), .i_wr_ready(wr_ready),
    .o_wr_addr(b_wr_addr), .o_wr_data(b_wr_data), .o_count(b_count), .o_done(b_done),
    .o_err(b_err), .o_err_code(b_err_code)
  );

  insn_encoder #(.BASE_ADDR(Base), .ADDR_W(4)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_restart(restart), .i_in_valid(in_valid),
    .o_in_ready(s_in_ready), .i_in_op(in_op), .i_in_rd(in_rd), .i_in_rs1(in_rs1),
    .i_in_rs2(in_rs2), .i_in_imm(in_imm), .i_in_funct(in_funct), .i_in_ls_mode(in_ls_mode),
    .i_in_is_store(in_is_store), .o_wr_valid(s_wr_valid), .i_wr_ready(wr_ready),
    .o_wr_addr(s_wr_addr), .o_wr_data(s_wr_data), .o_count(s_count), .o_done(s_done),
    .o_err(s_err), .o_err_code(s_err_code)
  );

  // Outputs of whichever instance is currently being scored.
  bit use_small;
  logic in_ready, wr_valid, done, err;
  logic [31:0] wr_addr, wr_data, count, err_code;
  always_comb begin
    if (use_small) begin
      in_ready = s_in_ready; wr_valid = s_wr_valid; done = s_done; err = s_err;
      wr_addr = 32'(s_wr_addr); wr_data = s_wr_data; count = 32'(s_count);
      err_code = 32'(s_err_code);
    end else begin
      in_ready = b_in_ready; wr_valid = b_wr_valid; done = b_done; err = b_err;
      wr_addr = 32'(b_wr_addr); wr_data = b_wr_data; count = 32'(b_count);
      err_code = 32'(b_err_code);
    end
  end

  int n_cmp, n_mis;
  logic [31:0] exp_q[$];
  int n_wr, exp_code;
  bit exp_halt, exp_done, exp_err, acc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference encoding: plain field arithmetic, wrapping modulo 2^32.
  function automatic logic [31:0] enc(input logic [31:0] op, rd, rs1, rs2, imm, funct, mode,
                                      st);
    case (op)
      1:       return op + rd * 64 + rs1 * 2048 + rs2 * 65536 + funct * 2097152;
      3, 4:    return op + rd * 64 + rs1 * 2048 + imm * 65536;
      2:       return op + (imm % 32) * 64 + (imm / 32) * 2097152;
      6, 7, 8: return op + (imm % 32) * 64 + (imm / 32) * 2097152 + rs1 * 2048 + rs2 * 65536;
      10:      return op + rd * 64 + rs1 * 2048 + (st * 32768 + mode) * 65536;
      default: return op;
    endcase
  endfunction

  // Called just after a negedge with inputs set; returns at the next negedge.
  task automatic cycle();
    bit clr;
    int code, target, aw;
    #1;
    clr = !rst_n || restart;
    acc = 0;
    aw  = use_small ? 4 : 12;
    if (!rst_n) check_eq("ready_in_reset", 32'(in_ready), 0);
    else if (!restart)
      check_eq("in_ready", 32'(in_ready),
               32'(!exp_halt && !exp_done && !exp_err && (exp_q.size() == 0 || wr_ready)));
    check_eq("wr_valid", 32'(wr_valid), 32'(exp_q.size() != 0));
    if (!clr) begin
      if (wr_valid && wr_ready) begin
        if (exp_q.size() != 0) begin
          check_eq("wr_addr", wr_addr, 32'(Base + 4 * n_wr));
          check_eq("wr_data", wr_data, exp_q.pop_front());
        end
        n_wr++;
        if (exp_halt && exp_q.size() == 0) begin
          exp_halt = 0;
          exp_done = 1;
        end
      end
      if (in_valid && in_ready) begin
        acc = 1;
        target = Base + 4 * (n_wr + exp_q.size());
        code = 0;
        if (int'(in_op) > 10) code = 1;
        else if (in_op == OpCompute && in_funct > 1) code = 2;
        else if (target > (1 << aw) - 4) code = 3;
        if (code != 0) begin
          exp_err  = 1;
          exp_code = code;
        end else begin
          exp_q.push_back(enc(32'(in_op), 32'(in_rd), 32'(in_rs1), 32'(in_rs2), 32'(in_imm),
                              32'(in_funct), 32'(in_ls_mode), 32'(in_is_store)));
          if (in_op == OpHlt) exp_halt = 1;
        end
      end
    end
    @(negedge clk);
    if (clr) begin
      exp_q.delete();
      n_wr = 0; exp_halt = 0; exp_done = 0; exp_err = 0; exp_code = 0;
      check_eq("addr_after_clear", wr_addr, 32'(Base));
      check_eq("data_after_clear", wr_data, 0);
    end
    check_eq("count", count, 32'(n_wr));
    check_eq("done", 32'(done), 32'(exp_done));
    check_eq("err", 32'(err), 32'(exp_err));
    check_eq("err_code", err_code, 32'(exp_code));
  endtask

  task automatic set_fields(input asm_op_e op, input logic [4:0] rd, rs1, rs2,
                            input logic [15:0] imm, input logic [10:0] funct,
                            input mem_mode_e m, input bit st);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_funct = funct; in_ls_mode = m; in_is_store = st;
  endtask

  task automatic send(input asm_op_e op, input logic [4:0] rd, rs1, rs2,
                      input logic [15:0] imm, input logic [10:0] funct,
                      input mem_mode_e m, input bit st);
    set_fields(op, rd, rs1, rs2, imm, funct, m, st);
    in_valid = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (acc) break;
    end
    if (!acc) check_eq("send_timeout", 32'(acc), 1);
    in_valid = 0;
  endtask

  task automatic rand_fields();
    int v;
    v = $urandom_range(0, 9);
    if (v >= 5) v++;
    in_op = asm_op_e'(6'(v));
    in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
    in_imm = 16'($urandom);
    in_funct = (in_op == OpCompute) ? 11'($urandom_range(0, 1)) : 11'($urandom);
    in_ls_mode = mem_mode_e'(2'($urandom_range(0, 2)));
    in_is_store = 1'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; restart = 0; in_valid = 0; wr_ready = 0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 0);
    check_eq("rst_wr_valid", 32'(wr_valid), 0);
    check_eq("rst_wr_addr", wr_addr, 32'(Base));
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_err_code", err_code, 0);
    rst_n = 1;
    exp_q.delete();
    n_wr = 0; exp_halt = 0; exp_done = 0; exp_err = 0; exp_code = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d0, a0;
    n_cmp = 0; n_mis = 0; use_small = 0;
    rst_n = 0; restart = 0; in_valid = 0; wr_ready = 0;
    set_fields(OpNop, 0, 0, 0, 0, 0, ModeW, 0);
    do_reset();

    // Directed encodings.
    send(OpAddi, 5'd3, 5'd1, 5'd0, 16'h0005, 11'd0, ModeW, 0);
    check_eq("addi_word", wr_data, 32'h000508C3);
    check_eq("addi_addr", wr_addr, 32'h0);
    wr_ready = 1;
    send(OpCompute, 5'd2, 5'd3, 5'd4, 16'h0, 11'd1, ModeW, 0);
    check_eq("compute_word", wr_data, 32'h00241881);
    check_eq("compute_addr", wr_addr, 32'h4);
    send(OpBeq, 5'd0, 5'd1, 5'd2, 16'hFFE0, 11'd0, ModeW, 0);
    check_eq("beq_word", wr_data, 32'hFFE20807);
    send(OpLwSw, 5'd7, 5'd9, 5'd0, 16'h0, 11'd0, ModeH, 1);
    check_eq("store_hi", 32'(wr_data[31:16]), 32'h8001);

    // Backpressure with a waiting instruction.
    wr_ready = 0;
    rand_fields();
    in_valid = 1;
    d0 = wr_data; a0 = wr_addr;
    repeat (3) begin
      cycle();
      check_eq("bp_data_stable", wr_data, d0);
      check_eq("bp_addr_stable", wr_addr, a0);
    end
    wr_ready = 1;
    repeat (6) begin
      cycle();
      rand_fields();
    end

    // Random traffic, legal ops without HLT.
    repeat (400) begin
      in_valid = 1'($urandom);
      wr_ready = ($urandom_range(0, 3) != 0);
      rand_fields();
      cycle();
    end
    in_valid = 0; wr_ready = 1;
    repeat (3) cycle();
    check_eq("queue_drained", 32'(exp_q.size()), 0);

    // HLT, then ignored input, then restart.
    wr_ready = 0;
    send(OpHlt, 5'd0, 5'd0, 5'd0, 16'h0, 11'd0, ModeW, 0);
    repeat (2) cycle();
    wr_ready = 1;
    set_fields(OpAddi, 5'd1, 5'd1, 5'd0, 16'h1234, 11'd0, ModeW, 0);
    in_valid = 1;
    repeat (6) cycle();
    check_eq("hlt_done", 32'(done), 1);
    restart = 1;
    cycle();
    restart = 0; in_valid = 0;
    check_eq("restart_count", count, 0);
    check_eq("restart_done", 32'(done), 0);

    // Error stops.
    send(OpAddi, 5'd4, 5'd5, 5'd0, 16'h00AA, 11'd0, ModeW, 0);
    send(OpCompute, 5'd1, 5'd2, 5'd3, 16'h0, 11'd5, ModeW, 0);
    check_eq("bad_funct_err", 32'(err), 1);
    check_eq("bad_funct_code", err_code, 32'(ErrBadFunct));
    in_valid = 1;
    repeat (2) cycle();
    in_valid = 0; restart = 1;
    cycle();
    restart = 0;
    send(asm_op_e'(6'd20), 5'd1, 5'd1, 5'd1, 16'h0, 11'd0, ModeW, 0);
    check_eq("bad_op_code", err_code, 32'(ErrBadOp));
    restart = 1;
    cycle();
    restart = 0;

    // Reset and restart while a write is stalled.
    wr_ready = 0;
    send(OpSubi, 5'd6, 5'd7, 5'd0, 16'hBEEF, 11'd0, ModeW, 0);
    rst_n = 0;
    cycle();
    rst_n = 1;
    check_eq("rst_drop_valid", 32'(wr_valid), 0);
    send(OpSubi, 5'd6, 5'd7, 5'd0, 16'hBEEF, 11'd0, ModeW, 0);
    check_eq("after_rst_addr", wr_addr, 32'(Base));
    restart = 1;
    cycle();
    restart = 0;
    check_eq("restart_drop_valid", 32'(wr_valid), 0);
    wr_ready = 1;
    send(OpJmp, 5'd0, 5'd0, 5'd0, 16'h0123, 11'd0, ModeW, 0);
    check_eq("after_restart_addr", wr_addr, 32'(Base));
    repeat (2) cycle();

    // Overflow on the 4-bit address instance.
    use_small = 1;
    do_reset();
    wr_ready = 1;
    repeat (5) begin
      rand_fields();
      in_op = OpAddi;
      send(in_op, in_rd, in_rs1, in_rs2, in_imm, in_funct, in_ls_mode, in_is_store);
    end
    cycle();
    check_eq("ovf_code", err_code, 32'(ErrOverflow));
    check_eq("ovf_count", count, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/insn_encoder.md
# insn_encoder

Streaming instruction encoder and instruction-memory writer: the write-side counterpart of the CPU's instruction decoder. It accepts one symbolic instruction per handshake, checks it, packs it into the 32-bit ISA word and writes it to consecutive instruction-memory addresses. It sits between the boot/debug loader and the instruction memory write port, and stops after encoding `HLT` or on the first illegal input.

## Interface
- `BASE_ADDR`, default 0: byte address of the first word written; must be 4-aligned.
- `ADDR_W`, default 12: width of `wrAddr`, in bytes of address space.
- `clk` input 1: single clock.
- `rstN` input 1: reset, synchronous, active-low.
- `restart` input 1: one-cycle pulse; rewinds to `BASE_ADDR` and clears status.
- `inValid` input 1: symbolic instruction present.
- `inReady` output 1: instruction accepted when `inValid && inReady`.
- `inOp` input `asm_op`: NOP, COMPUTE, JMP, ADDI, SUBI, HLT, BLT, BEQ, BNEQ, DEBUG_DUMPSTATE, LW_SW.
- `inRd`, `inRs1`, `inRs2` input `reg_select` (5 bits each): register fields.
- `inImm` input `cpu_half`: ADDI/SUBI immediate, or jump/branch target.
- `inFunct` input 11: COMPUTE function (0 = add, 1 = sub).
- `inLsMode` input `mem_mode`: memory width (W/H/B).
- `inIsStore` input 1: LW_SW direction.
- `wrValid` output 1: memory write pending.
- `wrReady` input 1: memory accepts the write when `wrValid && wrReady`.
- `wrAddr` output `ADDR_W`: byte address of the pending write.
- `wrData` output `cpu_word`: encoded instruction.
- `count` output `ADDR_W-1`: number of words written since reset or restart.
- `done` output 1: `HLT` has been written.
- `err` output 1: encoding stopped on an error.
- `errCode` output `enc_err`: NONE, BAD_OP, BAD_FUNCT, OVERFLOW.

## Operation
- Word layout: `[5:0]` opcode, `[10:6]` rd, `[15:11]` rs1, `[20:16]` rs2, `[31:21]` funct. Opcodes are NOP=0, COMPUTE=1, JMP=2, ADDI=3, SUBI=4, HLT=5, BLT=6, BEQ=7, BNEQ=8, DEBUG_DUMPSTATE=9, LW_SW=10.
- Encoding per instruction class:
  - **COMPUTE:** all fields are taken from the inputs.
  - **ADDI, SUBI:** rd, rs1, and `[31:16]` = `inImm`.
  - **JMP, BLT, BEQ, BNEQ:** `[31:21]` = `inImm[15:5]`, `[10:6]` = `inImm[4:0]`. Branches also carry rs1 and rs2. JMP sets rs1 and rs2 to 0.
  - **LW_SW:** rd, rs1, and `[31:16]` = `{inIsStore, 13'b0, mode}`, with mode W=0, H=1, B=2.
  - **NOP, HLT, DEBUG_DUMPSTATE:** opcode only; all other bits 0.
- Error checks on each accepted instruction:
  - `inOp` outside the enum gives BAD_OP.
  - COMPUTE with `inFunct > 1` gives BAD_FUNCT.
  - Accepting an instruction when the next address would exceed `2^ADDR_W - 4` gives OVERFLOW.
  - An erroring instruction is not written.
- States:
  - **RUN:** `inReady = !wrValid || wrReady`.
  - **HALTING:** entered when HLT is accepted. `inReady = 0`. Goes to DONE on the HLT write handshake.
  - **DONE:** `done = 1`, `inReady = 0`.
  - **ERR:** `err = 1`, `inReady = 0`, `errCode` held.
- DONE and ERR are left only by `restart` or reset.
- `restart` has priority over everything else in the same cycle:
  - a pending write is dropped (`wrValid` = 0 next cycle);
  - the address returns to `BASE_ADDR`, `count` to 0, and the state to RUN;
  - a handshake in that cycle is ignored.
- The address advances by 4 and `count` increments on each write handshake, not on acceptance.

## Timing
- Reset values: `wrValid` 0, `wrAddr` `BASE_ADDR`, `wrData` 0, `count` 0, `done` 0, `err` 0, `errCode` NONE, state RUN, `inReady` 0 while `rstN` is low.
- Latency: an instruction accepted in cycle N gives `wrValid` = 1 with its word in cycle N+1.
- Throughput: one word per cycle while `wrReady` = 1. The single output register is reloaded in the same cycle its write completes.
- While `wrValid && !wrReady`, `wrAddr` and `wrData` are stable and `inReady` = 0.
- An error is detected at acceptance; `err` = 1 in cycle N+1 and `wrValid` stays 0 for that instruction. A prior pending write still completes.
- `done` rises in the cycle after the HLT write handshake.

## Structure
- Package `base` gains the `asm_op` and `enc_err` enums, the opcode constants (replacing the per-file defines), and the field bit-position constants, all shared with the decoder.
- Sub-module `insn_pack`: purely combinational. It takes the `in*` fields and produces `{word, errCode}`. The top level holds the state machine, the output register, the address register and the counter.

## Test plan
- Encoding after reset: ADDI rd=3, rs1=1, imm=0x0005 gives `wrData` = 0x000508C3 at `wrAddr` 0 in cycle N+1. It is followed by COMPUTE funct=1, rd=2, rs1=3, rs2=4, giving 0x002418 81 at `wrAddr` 4.
- Branch split: BEQ rs1=1, rs2=2, imm=0xFFE0 gives 0xFFE20807.
- Store encoding: LW_SW store, mode H gives `[31:16]` = 0x8001.
- Backpressure: hold `wrReady` low 3 cycles with `inValid` high. `inReady` stays 0 and `wrData`/`wrAddr` stay stable; there is one write per handshake afterwards, `count` is exact, and no word is duplicated or lost.
- HLT: after HLT, `inReady` falls at once and `done` = 1 one cycle after the HLT write. Further `inValid` produces no writes. Then `restart` gives `wrAddr` 0, `count` 0, `done` 0.
- Errors: COMPUTE with funct=5 gives `err` with BAD_FUNCT and no write for it. With `ADDR_W` = 4, the fifth instruction gives OVERFLOW after writes at 0, 4, 8 and 12.
- Mid-operation reset and restart: assert `rstN` = 0 or `restart` while `wrValid && !wrReady`. The pending write is dropped, all outputs return to their reset values, and the next accepted word goes to `BASE_ADDR`.
